mux_scan_selector: RTL and testbench

- Parametrised, registered N-to-1 word selector for the Maxnet datapath.
- Generalises the combinational 4:1 mux to N channels of WIDTH bits, with a registered output and a valid/ready handshake.
- Adds an auto-scan mode that steps through all channels enabled in a mask, in ascending index order, one word per handshake. The Maxnet controller uses it to stream surviving neuron values to the shared arithmetic unit.

---
 rtl/mux_scan_selector_if.sv | 31 +++
 rtl/mux_scan_selector.sv | 115 +++++++++++
 tb/tb_mux_scan_selector.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_selector_if.sv
// Handshake and data bundle for mux_scan_selector.
// The master side drives requests and consumes words. The slave side is the selector.
interface mux_scan_selector_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
);
  logic                 mode;
  logic [SEL_W-1:0]     sel;
  logic                 sel_load;
  logic                 start;
  logic [N-1:0]         ch_mask;
  logic [N*WIDTH-1:0]   in_data;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_index;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;
  logic                 sel_err;

  modport master (
    output mode, sel, sel_load, start, ch_mask, in_data, out_ready,
    input  out_data, out_index, out_valid, busy, done, sel_err
  );

  modport slave (
    input  mode, sel, sel_load, start, ch_mask, in_data, out_ready,
    output out_data, out_index, out_valid, busy, done, sel_err
  );
endinterface

// File: rtl/mux_scan_selector.sv
// Registered N-to-1 word selector with a valid/ready output.
// Auto-scan streams every mask-enabled channel in ascending order, one word per handshake.
module mux_scan_selector #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input logic                clk,
  input logic                rst,
  mux_scan_selector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t           state;
  logic [N-1:0]     mask_q;
  logic [WIDTH-1:0] words [N];
  logic [SEL_W:0]   start_hit;
  logic [SEL_W:0]   next_hit;
  logic             sel_ok;
  logic             handshake;

  // Returns {found, index} for the lowest set bit of m at or above position lo.
  function automatic logic [SEL_W:0] first_set(input logic [N-1:0] m, input int lo);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i] && i >= lo) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) words[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  // The successor search starts one above the current index in int arithmetic, so it cannot wrap.
  assign start_hit = first_set(bus.ch_mask, 0);
  assign next_hit  = first_set(mask_q, int'(bus.out_index) + 1);
  assign sel_ok    = int'(bus.sel) < N;
  assign handshake = bus.out_valid && bus.out_ready;

  // NOTE: all state and outputs are updated with non-blocking assignments, so every branch
  // sees the values from before the edge, whatever order the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mask_q        <= '0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.sel_err   <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.sel_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.mode && bus.sel_load) begin
            if (sel_ok) begin
              bus.out_data  <= words[bus.sel];
              bus.out_index <= bus.sel;
              bus.out_valid <= 1'b1;
              state         <= DIRECT;
            end else begin
              bus.sel_err <= 1'b1;
            end
          end else if (bus.mode && bus.start) begin
            mask_q <= bus.ch_mask;
            if (start_hit[SEL_W]) begin
              bus.out_data  <= words[start_hit[SEL_W-1:0]];
              bus.out_index <= start_hit[SEL_W-1:0];
              bus.out_valid <= 1'b1;
              bus.busy      <= 1'b1;
              state         <= SCAN;
            end else begin
              bus.done <= 1'b1;
            end
          end
        end

        DIRECT: begin
          if (handshake) begin
            if (bus.sel_load && sel_ok) begin
              bus.out_data  <= words[bus.sel];
              bus.out_index <= bus.sel;
            end else begin
              bus.out_valid <= 1'b0;
              bus.sel_err   <= bus.sel_load;
              state         <= IDLE;
            end
          end
        end

        SCAN: begin
          if (handshake) begin
            if (next_hit[SEL_W]) begin
              bus.out_data  <= words[next_hit[SEL_W-1:0]];
              bus.out_index <= next_hit[SEL_W-1:0];
            end else begin
              bus.out_valid <= 1'b0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              state         <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_selector.sv
// Self-checking bench for mux_scan_selector: a vector table, corner-case sequences,
// and randomized direct/scan traffic compared against a transaction-level model.
module tb_mux_scan_selector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_scan_selector_if #(.N(4), .WIDTH(32), .SEL_W(2)) b4 ();
  mux_scan_selector_if #(.N(3), .WIDTH(32), .SEL_W(2)) b3 ();

  mux_scan_selector #(.N(4), .WIDTH(32), .SEL_W(2)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mux_scan_selector #(.N(3), .WIDTH(32), .SEL_W(2)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cur [4];

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic        sel_load;
    logic        start;
    logic [3:0]  mask;
    logic        ready;
    logic        ev;
    logic [1:0]  ei;
    logic [31:0] ed;
    logic        eb;
    logic        edn;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set4();
    b4.in_data = {cur[3], cur[2], cur[1], cur[0]};
  endtask

  task automatic base_words();
    cur[0] = 32'hAAAA_00A0; cur[1] = 32'hBBBB_00B1;
    cur[2] = 32'hCCCC_00C2; cur[3] = 32'hDDDD_00D3;
    set4();
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++) cur[i] = $urandom;
    set4();
  endtask

  task automatic idle4();
    b4.mode = 1'b0; b4.sel = '0; b4.sel_load = 1'b0; b4.start = 1'b0; b4.ch_mask = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        sl, rd, m_valid, fin;
    logic [1:0]  s, m_idx;
    logic [31:0] m_data, exp_d, held;
    logic [3:0]  mask;
    int          q[$];
    int          exp_i;
    bit          ended;

    idle4(); base_words(); b4.out_ready = 1'b0;
    b3.mode = 1'b0; b3.sel = '0; b3.sel_load = 1'b0; b3.start = 1'b0; b3.ch_mask = '0;
    b3.out_ready = 1'b1;
    b3.in_data = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

    // Reset state
    tick();
    check("rst_valid", b4.out_valid, 0);
    check("rst_data",  b4.out_data,  0);
    check("rst_index", b4.out_index, 0);
    check("rst_busy",  b4.busy,      0);
    check("rst_done",  b4.done,      0);
    check("rst_err",   b4.sel_err,   0);
    rst = 1'b0;

    // mode sel sl st mask rdy | valid idx data busy done
    tbl[0]  = '{1'b0, 2'd2, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 32'hCCCC_00C2, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 2'd0, 32'hAAAA_00A0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 2'd1, 32'hBBBB_00B1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 32'hCCCC_00C2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 32'hDDDD_00D3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 32'hAAAA_00A0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 2'd3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 32'hAAAA_00A0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 2'd3, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 32'hDDDD_00D3, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      b4.mode = tbl[i].mode; b4.sel = tbl[i].sel; b4.sel_load = tbl[i].sel_load;
      b4.start = tbl[i].start; b4.ch_mask = tbl[i].mask; b4.out_ready = tbl[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), b4.out_valid, tbl[i].ev);
      check($sformatf("vec%0d_busy", i),  b4.busy,      tbl[i].eb);
      check($sformatf("vec%0d_done", i),  b4.done,      tbl[i].edn);
      check($sformatf("vec%0d_err", i),   b4.sel_err,   0);
      if (tbl[i].ev) begin
        check($sformatf("vec%0d_index", i), b4.out_index, tbl[i].ei);
        check($sformatf("vec%0d_data", i),  b4.out_data,  tbl[i].ed);
      end
    end

    // Scan of 1010 under backpressure with in_data changing while held
    idle4(); base_words();
    b4.mode = 1'b1; b4.start = 1'b1; b4.ch_mask = 4'b1010; b4.out_ready = 1'b0;
    tick();
    check("bp_first_index", b4.out_index, 1);
    check("bp_first_data",  b4.out_data,  32'hBBBB_00B1);
    b4.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_words();
      tick();
      check("bp_hold_valid", b4.out_valid, 1);
      check("bp_hold_index", b4.out_index, 1);
      check("bp_hold_data",  b4.out_data,  32'hBBBB_00B1);
    end
    b4.out_ready = 1'b1;
    tick();
    check("bp_next_index", b4.out_index, 3);
    check("bp_next_data",  b4.out_data,  cur[3]);
    tick();
    check("bp_end_valid", b4.out_valid, 0);
    check("bp_end_done",  b4.done,      1);
    check("bp_end_busy",  b4.busy,      0);

    // Asynchronous reset in the middle of a scan
    idle4(); base_words(); tick();
    b4.mode = 1'b1; b4.start = 1'b1; b4.ch_mask = 4'hF; b4.out_ready = 1'b1;
    tick();
    b4.start = 1'b0;
    tick();
    check("mid_index1", b4.out_index, 1);
    b4.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", b4.out_valid, 0);
    check("arst_data",  b4.out_data,  0);
    check("arst_index", b4.out_index, 0);
    check("arst_busy",  b4.busy,      0);
    check("arst_done",  b4.done,      0);
    tick();
    check("arst_no_done", b4.done, 0);
    rst = 1'b0;
    b4.start = 1'b1; b4.out_ready = 1'b1;
    tick();
    check("restart_index", b4.out_index, 0);
    check("restart_busy",  b4.busy,      1);
    idle4();
    do_reset();

    // Out-of-range selects on the 3-channel build
    b3.sel = 2'd3; b3.sel_load = 1'b1;
    tick();
    check("n3_err_pulse", b3.sel_err,   1);
    check("n3_err_valid", b3.out_valid, 0);
    b3.sel_load = 1'b0;
    tick();
    check("n3_err_clear", b3.sel_err,   0);
    check("n3_idle_valid", b3.out_valid, 0);
    b3.sel = 2'd2; b3.sel_load = 1'b1;
    tick();
    check("n3_load_valid", b3.out_valid, 1);
    check("n3_load_data",  b3.out_data,  32'h3333_0002);
    b3.sel = 2'd3;
    tick();
    check("n3_hs_bad_valid", b3.out_valid, 0);
    check("n3_hs_bad_err",   b3.sel_err,   1);
    b3.sel_load = 1'b0;
    tick();
    check("n3_hs_bad_clear", b3.sel_err, 0);

    // Randomized direct mode against a word-level model
    idle4();
    m_valid = 1'b0; m_idx = '0; m_data = '0;
    for (int c = 0; c < 300; c++) begin
      sl = 1'($urandom_range(0, 1)); s = 2'($urandom_range(0, 3)); rd = 1'($urandom_range(0, 1));
      b4.sel_load = sl; b4.sel = s; b4.out_ready = rd;
      rand_words();
      if (m_valid ? (rd && sl) : sl) begin
        m_valid = 1'b1; m_idx = s; m_data = cur[s];
      end else if (m_valid && rd) begin
        m_valid = 1'b0;
      end
      tick();
      check("rd_valid", b4.out_valid, m_valid);
      check("rd_busy",  b4.busy,      0);
      if (m_valid) begin
        check("rd_index", b4.out_index, m_idx);
        check("rd_data",  b4.out_data,  m_data);
      end
    end
    idle4(); b4.out_ready = 1'b1;
    tick();

    // Randomized scans: expected order is the list of enabled channels
    for (int t = 0; t < 40; t++) begin
      mask = 4'($urandom_range(0, 15));
      q.delete();
      for (int i = 0; i < 4; i++) if (mask[i]) q.push_back(i);
      idle4(); rand_words();
      b4.mode = 1'b1; b4.start = 1'b1; b4.ch_mask = mask;
      b4.out_ready = 1'($urandom_range(0, 1));
      exp_i = 0; exp_d = '0;
      if (q.size() > 0) begin
        exp_i = q.pop_front(); exp_d = cur[exp_i];
      end
      tick();
      if (mask == 4'h0) begin
        check("rs_empty_done",  b4.done,      1);
        check("rs_empty_valid", b4.out_valid, 0);
        check("rs_empty_busy",  b4.busy,      0);
        continue;
      end
      check("rs_first_index", b4.out_index, exp_i);
      check("rs_first_data",  b4.out_data,  exp_d);
      check("rs_first_busy",  b4.busy,      1);
      held = exp_d;
      ended = 1'b0;
      for (int c = 0; c < 200 && !ended; c++) begin
        rd = b4.out_ready;
        fin = 1'b0;
        if (rd) begin
          if (q.size() > 0) begin
            exp_i = q.pop_front(); exp_d = cur[exp_i];
          end else begin
            fin = 1'b1;
          end
        end
        tick();
        if (fin) begin
          check("rs_end_valid", b4.out_valid, 0);
          check("rs_end_done",  b4.done,      1);
          check("rs_end_busy",  b4.busy,      0);
          ended = 1'b1;
        end else begin
          check("rs_valid", b4.out_valid, 1);
          check("rs_index", b4.out_index, exp_i);
          check("rs_data",  b4.out_data,  exp_d);
          check("rs_done",  b4.done,      0);
        end
        // Noise that must be ignored while busy, plus the next ready decision
        b4.mode = 1'($urandom_range(0, 1)); b4.start = 1'($urandom_range(0, 1));
        b4.sel_load = 1'($urandom_range(0, 1)); b4.sel = 2'($urandom_range(0, 3));
        b4.ch_mask = 4'($urandom_range(0, 15));
        b4.out_ready = 1'($urandom_range(0, 1));
        rand_words();
      end
      if (!ended) begin
        n_checks++; n_fail++;
        $display("FAIL rs_timeout: scan with mask %0h did not finish within 200 cycles", mask);
        idle4();
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
